// File: rtl/mem_pipe.sv
// rtl/mem_pipe.sv - byte-enabled memory with a fixed-latency read pipe and a response FIFO
module mem_pipe #(
    parameter int AWIDTH       = 10,
    parameter int DWIDTH       = 32,
    parameter int RD_LATENCY   = 2,
    parameter int RSP_DEPTH    = 4,
    parameter int STALL_PERIOD = 0,
    localparam int DBYTES      = DWIDTH / 8,
    localparam int OWIDTH      = $clog2(RSP_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    input  logic [DBYTES-1:0] req_ben,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic [OWIDTH-1:0] outstanding
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam int PW    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] fifo_mem [RSP_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [OWIDTH-1:0] fifo_cnt, out_cnt;
    logic              stall, accept, rd_accept, wr_accept, push, pop;
    logic [DWIDTH-1:0] push_data;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rsp_valid   = !rst && (fifo_cnt != '0);
    assign pop         = rsp_valid && rsp_ready;
    // A pop in the same cycle frees the slot a new read would need.
    assign req_ready   = !rst && !stall && ((out_cnt < OWIDTH'(RSP_DEPTH)) || pop);
    assign accept      = req_valid && req_ready;
    assign rd_accept   = accept && !req_write;
    assign wr_accept   = accept && req_write;
    assign outstanding = rst ? '0 : out_cnt;
    assign rsp_rdata   = rsp_valid ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        for (int b = 0; b < DBYTES; b++) begin
            if (wr_accept && req_ben[b]) begin
                mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
            end
        end
    end

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            assign push      = rd_accept;
            assign push_data = mem[req_addr];
        end else begin : g_pipe
            logic [RD_LATENCY-2:0] pv;
            logic [DWIDTH-1:0]     pd [RD_LATENCY-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    pv <= '0;
                end else begin
                    pv[0] <= rd_accept;
                    for (int i = 1; i < RD_LATENCY - 1; i++) begin
                        pv[i] <= pv[i-1];
                    end
                end
            end

            // Data is snapshotted at acceptance, so later writes cannot leak in.
            always_ff @(posedge clk) begin
                pd[0] <= mem[req_addr];
                for (int i = 1; i < RD_LATENCY - 1; i++) begin
                    pd[i] <= pd[i-1];
                end
            end

            assign push      = pv[RD_LATENCY-2];
            assign push_data = pd[RD_LATENCY-2];
        end
    endgenerate

    generate
        if (STALL_PERIOD == 0) begin : g_nostall
            assign stall = 1'b0;
        end else begin : g_stall
            localparam int SW = $clog2(STALL_PERIOD);
            logic [SW-1:0] scnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    scnt <= '0;
                end else begin
                    scnt <= (scnt == SW'(STALL_PERIOD - 1)) ? '0 : scnt + 1'b1;
                end
            end

            assign stall = (scnt == SW'(STALL_PERIOD - 1));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            out_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            case ({rd_accept, pop})
                2'b10:   out_cnt <= out_cnt + 1'b1;
                2'b01:   out_cnt <= out_cnt - 1'b1;
                default: out_cnt <= out_cnt;
            endcase
        end
    end

endmodule

// File: doc/mem_pipe.md
MEM_PIPE -- requirements
Module: mem_pipe

Interface
REQ-001 SHALL have parameter AWIDTH, default 10, address width; DEPTH = 2**AWIDTH words.
REQ-002 SHALL have parameter DWIDTH, default 32, data width, a multiple of 8; DBYTES = DWIDTH/8 (localparam).
REQ-003 SHALL have parameter RD_LATENCY, default 2, range 1..8, cycles from read acceptance to response available.
REQ-004 SHALL have parameter RSP_DEPTH, default 4, response FIFO depth, RSP_DEPTH >= 1.
REQ-005 SHALL have parameter STALL_PERIOD, default 0, forced-stall period; 0 = none, else >= 2.
REQ-006 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port req_valid  input  1  request present.
REQ-009 SHALL have port req_ready  output  1  request may be accepted this cycle.
REQ-010 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-011 SHALL have port req_addr  input  AWIDTH  word address.
REQ-012 SHALL have port req_wdata  input  DWIDTH  write data.
REQ-013 SHALL have port req_ben  input  DBYTES  byte enables; bit i covers data[8i+7:8i].
REQ-014 SHALL have port rsp_valid  output  1  read response at FIFO head.
REQ-015 SHALL have port rsp_ready  input  1  consumer takes response.
REQ-016 SHALL have port rsp_rdata  output  DWIDTH  read data.
REQ-017 SHALL have port outstanding  output  $clog2(RSP_DEPTH+1)  reads in the latency pipe plus reads held in the FIFO.

Function
REQ-018 SHALL accept a request on an edge where req_valid && req_ready; one request per cycle maximum.
REQ-019 SHALL, for an accepted write, update at that edge only the bytes with req_ben set; no response is produced; req_ben = 0 is a legal no-op.
REQ-020 SHALL, for an accepted read, capture mem[req_addr] as it stood before that edge; writes accepted later never alter the captured data.
REQ-021 SHALL make a read accepted at edge k push to the FIFO at edge k+RD_LATENCY-1, so rsp_valid is high in the cycle after edge k+RD_LATENCY-1 at the earliest (RD_LATENCY=1: the cycle after acceptance).
REQ-022 SHALL return responses in acceptance order.
REQ-023 SHALL pop a response on an edge where rsp_valid && rsp_ready; the FIFO is first-word fall-through.
REQ-024 SHALL drive rsp_rdata to the FIFO head when rsp_valid = 1, and to 0 otherwise.
REQ-025 SHALL increment outstanding on read accept and decrement it on pop; simultaneous accept and pop leave it unchanged.
REQ-026 SHALL drive req_ready = !rst && !stall && (outstanding < RSP_DEPTH || rsp_ready && rsp_valid); the FIFO can never overflow.
REQ-027 SHALL, with rsp_ready held low, accept reads until outstanding = RSP_DEPTH, then hold req_ready low; writes are also blocked (single in-order request port).
REQ-028 SHALL, when STALL_PERIOD = N > 0, run a free counter 0..N-1 that wraps to 0; stall = (counter == N-1), forcing req_ready low for 1 cycle every N.
REQ-029 SHALL allow any bit pattern on request fields while req_valid = 0, with no effect on state.
REQ-030 SHALL leave memory contents uninitialised (X) until first write; no init port.

Reset
REQ-031 SHALL, while rst = 1 at an edge, clear the pipe valids, FIFO pointers, outstanding and the stall counter; memory contents are retained.
REQ-032 SHALL hold req_ready = 0 and rsp_valid = 0 during reset, with rsp_rdata = 0 and outstanding = 0; requests presented during reset are ignored.
REQ-033 SHALL discard reads in flight or queued when reset is asserted mid-operation; none appear after reset.

Verification
REQ-034 SHALL pass this case: DWIDTH=32, write 0xAABBCCDD to addr 5 with ben 4'b1111, then write 0x11223344 with ben 4'b0101, then read addr 5 -> rsp_rdata = 0xAA22CC44.
REQ-035 SHALL pass this case: RD_LATENCY=3, read accepted at edge 10, rsp_ready=1 -> rsp_valid rises in the cycle after edge 12 and is popped at edge 13; outstanding reads 1 from edge 10 through edge 12 and 0 after edge 13.
REQ-036 SHALL pass this case: RSP_DEPTH=4, rsp_ready=0, back-to-back reads -> exactly 4 accepted, req_ready=0 and outstanding=4; raising rsp_ready -> one accept per pop and order preserved.
REQ-037 SHALL pass this case: read addr 7 (holds 0x1) accepted, then write 0x2 to addr 7 on the next cycle -> response 0x1; a following read returns 0x2.
REQ-038 SHALL pass this case: STALL_PERIOD=4, req_valid held high -> req_ready low on cycles 3, 7, 11 after reset release and high otherwise.
REQ-039 SHALL pass this case: rst asserted with 2 reads in flight -> after release rsp_valid=0 and outstanding=0, and memory retains prior writes.
